// File: rtl/packet_tx.sv
// Packet transmitter: emits a six-word header, a clamped sink count read from memory,
// then one word per known sink fetched from memory, over a valid/ready stream.
module packet_tx (
  input  logic        clock,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] MY_NODE_ID,
  input  logic [15:0] MY_CLUSTER_ID,
  input  logic [15:0] MY_BATTERY_STAT,
  input  logic [15:0] action,
  input  logic [15:0] mybest,
  input  logic        forAggregation,
  output logic [15:0] address,
  output logic        wr_en,
  input  logic [15:0] mem_data_out,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_last,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND_HDR  = 3'd1,
    RD_CNT    = 3'd2,
    SEND_CNT  = 3'd3,
    RD_SINK   = 3'd4,
    SEND_SINK = 3'd5,
    DONE      = 3'd6
  } state_t;

  localparam logic [15:0] SINK_CNT_ADDR = 16'h0688;
  localparam logic [15:0] SINK_BASE     = 16'h0008;
  localparam logic [4:0]  MAX_SINKS     = 5'd16;

  state_t      state;
  logic [15:0] hdr_q [0:5];
  logic [2:0]  hdr_idx;
  logic [4:0]  count;
  logic [4:0]  sink_idx;

  // Raw counts above the sink table size are clamped to the table size.
  function automatic logic [4:0] clamp_count(input logic [15:0] raw);
    return (raw > {11'd0, MAX_SINKS}) ? MAX_SINKS : raw[4:0];
  endfunction

  // The block only ever reads memory.
  assign wr_en = 1'b0;

  always_ff @(posedge clock) begin
    if (rst) begin
      state    <= IDLE;
      hdr_idx  <= 3'd0;
      count    <= 5'd0;
      sink_idx <= 5'd0;
      address  <= 16'd0;
      tx_data  <= 16'd0;
      tx_valid <= 1'b0;
      tx_last  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        hdr_q[i] <= 16'd0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start && !done) begin
            hdr_q[0] <= action;
            hdr_q[1] <= MY_NODE_ID;
            hdr_q[2] <= MY_CLUSTER_ID;
            hdr_q[3] <= MY_BATTERY_STAT;
            hdr_q[4] <= mybest;
            hdr_q[5] <= {15'd0, forAggregation};
            hdr_idx  <= 3'd0;
            tx_data  <= action;
            tx_valid <= 1'b1;
            tx_last  <= 1'b0;
            busy     <= 1'b1;
            state    <= SEND_HDR;
          end
        end
        SEND_HDR: begin
          if (tx_ready) begin
            if (hdr_idx == 3'd5) begin
              tx_valid <= 1'b0;
              address  <= SINK_CNT_ADDR;
              state    <= RD_CNT;
            end else begin
              hdr_idx <= hdr_idx + 3'd1;
              tx_data <= hdr_q[hdr_idx + 3'd1];
            end
          end
        end
        RD_CNT: begin
          // Memory returns the word addressed during this cycle at its closing edge.
          count    <= clamp_count(mem_data_out);
          tx_data  <= {11'd0, clamp_count(mem_data_out)};
          tx_last  <= (clamp_count(mem_data_out) == 5'd0);
          tx_valid <= 1'b1;
          sink_idx <= 5'd0;
          address  <= 16'd0;
          state    <= SEND_CNT;
        end
        SEND_CNT: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            tx_last  <= 1'b0;
            if (tx_last) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              address <= SINK_BASE;
              state   <= RD_SINK;
            end
          end
        end
        RD_SINK: begin
          tx_data  <= mem_data_out;
          tx_valid <= 1'b1;
          tx_last  <= (sink_idx == count - 5'd1);
          address  <= 16'd0;
          state    <= SEND_SINK;
        end
        SEND_SINK: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            tx_last  <= 1'b0;
            if (tx_last) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              sink_idx <= sink_idx + 5'd1;
              address  <= SINK_BASE + {10'd0, sink_idx + 5'd1, 1'b0};
              state    <= RD_SINK;
            end
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_packet_tx.sv
// Scoreboard bench for packet_tx: stimulus pushes expected words/addresses,
// a negedge monitor pops and compares on every handshake or memory read.
module tb_packet_tx;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] MY_NODE_ID = 16'd0;
  logic [15:0] MY_CLUSTER_ID = 16'd0;
  logic [15:0] MY_BATTERY_STAT = 16'd0;
  logic [15:0] action = 16'd0;
  logic [15:0] mybest = 16'd0;
  logic        forAggregation = 1'b0;
  logic [15:0] address;
  logic        wr_en;
  logic [15:0] mem_data_out;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        tx_last;
  logic        busy;
  logic        done;

  logic [15:0] mem [0:4095];
  assign mem_data_out = mem[address[11:0]];

  packet_tx dut (
    .clock(clock), .rst(rst), .start(start),
    .MY_NODE_ID(MY_NODE_ID), .MY_CLUSTER_ID(MY_CLUSTER_ID),
    .MY_BATTERY_STAT(MY_BATTERY_STAT), .action(action), .mybest(mybest),
    .forAggregation(forAggregation), .address(address), .wr_en(wr_en),
    .mem_data_out(mem_data_out), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_last(tx_last), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [16:0] exp_q [$];
  logic [15:0] addr_q [$];
  bit          last_xfer = 1'b0;
  logic [16:0] mon_w;
  logic [15:0] mon_a;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    check(name, {tx_data, tx_valid, tx_last, busy, done, address, wr_en}, 64'd0);
  endtask

  // Monitor: compare every transferred word and every memory read address.
  always @(negedge clock) begin
    if (!rst) begin
      check("wr_en", wr_en, 64'd0);
      if (last_xfer) begin
        check("after_last", {done, busy, tx_valid}, 64'b100);
        last_xfer = 1'b0;
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", {tx_last, tx_data}, 64'h1_FFFF_FFFF);
        end else begin
          mon_w = exp_q.pop_front();
          check("tx_word", {tx_last, tx_data}, mon_w);
          last_xfer = tx_last;
        end
      end
      if (address != 16'd0) begin
        if (addr_q.size() == 0) begin
          check("unexpected_addr", address, 64'h1_0000);
        end else begin
          mon_a = addr_q.pop_front();
          check("rd_addr", address, mon_a);
        end
      end
    end
  end

  task automatic do_reset();
    start = 1'b0;
    tx_ready = 1'b1;
    rst = 1'b1;
    @(posedge clock); #1;
    rst = 1'b0;
    exp_q.delete();
    addr_q.delete();
    last_xfer = 1'b0;
    check_outputs_zero("reset_outputs");
  endtask

  // Queue the expected packet, then raise start; returns one step after the capture edge.
  task automatic launch(input logic [15:0] a, input logic [15:0] nid, input logic [15:0] cid,
                        input logic [15:0] bat, input logic [15:0] best, input logic fa,
                        input int cnt, input bit hold);
    int n;
    logic [15:0] ad;
    action = a; MY_NODE_ID = nid; MY_CLUSTER_ID = cid;
    MY_BATTERY_STAT = bat; mybest = best; forAggregation = fa;
    mem[12'h688] = cnt[15:0];
    n = (cnt > 16) ? 16 : cnt;
    exp_q.push_back({1'b0, a});
    exp_q.push_back({1'b0, nid});
    exp_q.push_back({1'b0, cid});
    exp_q.push_back({1'b0, bat});
    exp_q.push_back({1'b0, best});
    exp_q.push_back({1'b0, 15'd0, fa});
    exp_q.push_back({(n == 0), n[15:0]});
    addr_q.push_back(16'h0688);
    for (int i = 0; i < n; i++) begin
      ad = 16'(8 + 2 * i);
      addr_q.push_back(ad);
      exp_q.push_back({(i == n - 1), mem[ad[11:0]]});
    end
    start = 1'b1;
    @(posedge clock); #1;
    check("first_word_latency", {busy, tx_valid, tx_data}, {2'b11, a});
    if (!hold) start = 1'b0;
    action = 16'hDEAD; MY_NODE_ID = 16'hBEEF; MY_CLUSTER_ID = 16'hCAFE;
    MY_BATTERY_STAT = 16'hF00D; mybest = 16'h7777; forAggregation = ~fa;
  endtask

  task automatic wait_done(input int exp_cycles, input bit timed);
    int c = 0;
    while (!done && c < 300) begin
      @(posedge clock); #1;
      c++;
    end
    check("done_reached", done, 64'd1);
    if (timed) check("packet_cycles", c, exp_cycles);
    repeat (2) begin
      @(posedge clock); #1;
    end
    check("words_left", exp_q.size(), 64'd0);
    check("addrs_left", addr_q.size(), 64'd0);
  endtask

  initial begin
    int k;
    for (int i = 0; i < 4096; i++) mem[i] = 16'd0;
    for (int i = 0; i < 20; i++) mem[8 + 2 * i] = 16'(16'h0A00 + i);
    mem[8] = 16'h0011;
    mem[10] = 16'h0022;

    @(posedge clock); #1;
    do_reset();

    // Zero sinks, start held high afterwards: packet ends at word 7, nothing further.
    launch(16'd5, 16'd3, 16'd1, 16'h8000, 16'd10, 1'b0, 0, 1'b1);
    wait_done(8, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      check("one_shot", {done, busy, tx_valid}, 64'b100);
    end
    do_reset();

    // Two sinks.
    launch(16'd7, 16'd3, 16'd2, 16'h1234, 16'h0055, 1'b1, 2, 1'b0);
    wait_done(12, 1'b1);
    do_reset();

    // Clamp: raw count 40 yields 16 sink reads at 0x8..0x26.
    mem[8] = 16'h0A00;
    mem[10] = 16'h0A01;
    launch(16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500, 1'b0, 40, 1'b0);
    wait_done(40, 1'b1);
    do_reset();

    // Backpressure while word 2 is presented.
    launch(16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505, 1'b1, 1, 1'b0);
    k = 0;
    while (!(tx_valid && tx_data == 16'h0303) && k < 20) begin
      @(posedge clock); #1;
      k++;
    end
    check("bp_word2_seen", {tx_valid, tx_data}, {1'b1, 16'h0303});
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      check("bp_hold", {tx_valid, tx_last, tx_data}, {2'b10, 16'h0303});
    end
    tx_ready = 1'b1;
    wait_done(0, 1'b0);
    do_reset();

    // Reset during SEND_SINK, then a full restart from word 0.
    mem[8] = 16'h0011;
    mem[10] = 16'h0022;
    launch(16'h0009, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 1'b0, 2, 1'b0);
    k = 0;
    while (!(tx_valid && tx_data == 16'h0011) && k < 30) begin
      @(posedge clock); #1;
      k++;
    end
    check("mid_sink_seen", {tx_valid, tx_data}, {1'b1, 16'h0011});
    tx_ready = 1'b0;
    rst = 1'b1;
    @(posedge clock); #1;
    check_outputs_zero("mid_reset_outputs");
    rst = 1'b0;
    exp_q.delete();
    addr_q.delete();
    last_xfer = 1'b0;
    tx_ready = 1'b1;
    @(posedge clock); #1;
    check_outputs_zero("idle_after_reset");
    launch(16'h0009, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 1'b0, 2, 1'b0);
    wait_done(12, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
